// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared definitions for the SPI ROM read scheduler.
//   state_t    - scheduler FSM states
//   READ_CMD   - SPI flash READ opcode sent at the start of every transaction
//   GAP_CYCLES - chip-select-low cycles enforced after every transaction
package spi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    GAP
  } state_t;

  localparam logic [7:0] READ_CMD = 8'h03;
  localparam int unsigned GAP_CYCLES = 2;

endpackage

// File: rtl/spi_shift.sv
// spi_shift: SPI mode-0 bit engine (clk/2 sclk, MOSI shift-out, MISO shift-in,
// bit counter) for the ROM read scheduler.
// Ports:
//   clk, rst_n   - system clock, synchronous active-low reset
//   start        - load command + address, begin at sclk low
//   stop         - end of transaction: sclk and mosi forced low
//   active       - serializer running (CMD/ADDR/DATA)
//   addr         - start address loaded on start
//   miso         - serial input from the memory
//   sclk, mosi   - registered SPI outputs
//   byte_end     - last cycle (sclk high, bit 7) of the current byte
//   sample_last  - the coming edge samples bit 0 of the current byte
//   rx_next      - received byte including the bit sampled on the coming edge
import spi_sched_pkg::*;

module spi_shift #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              active,
  input  logic [ADDR_W-1:0] addr,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              byte_end,
  output logic              sample_last,
  output logic [7:0]        rx_next
);

  logic [ADDR_W+7:0] tx;
  logic [7:0]        rx;
  logic [2:0]        bit_cnt;

  always_comb begin
    rx_next     = {rx[6:0], miso};
    byte_end    = active && sclk && (bit_cnt == 3'd7);
    sample_last = active && !sclk && (bit_cnt == 3'd7);
  end

  // The command MSB goes straight onto mosi at start; the rest of the command
  // and the address queue up behind it in tx, shifted out on each falling sclk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      sclk    <= 1'b0;
      mosi    <= READ_CMD[7];
      tx      <= {READ_CMD[6:0], addr, 1'b0};
      rx      <= '0;
      bit_cnt <= '0;
    end else if (stop) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      bit_cnt <= '0;
    end else if (active) begin
      sclk <= ~sclk;
      if (!sclk) begin
        rx <= rx_next;
      end else begin
        mosi    <= tx[ADDR_W+7];
        tx      <= {tx[ADDR_W+6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/spi_rom_sched.sv
// spi_rom_sched: two-requester SPI flash read scheduler. Arbitrates between
// the video line fetch (req[0]) and an auxiliary requester (req[1]), issues
// READ (03h) + address, streams len bytes back, then enforces a CS-low gap.
// Optional build macro: SPI_SCHED_RR_EN selects round-robin arbitration;
// without it req[0] has fixed priority.
// Ports:
//   clk, rst_n          - system clock, synchronous active-low reset
//   req[1:0]            - read requests
//   addr0/addr1         - start address per requester
//   len0/len1           - byte count per requester (0 = 2^LEN_W)
//   gnt[1:0]            - one-cycle grant pulse
//   rd_valid/data/id    - received byte strobe, byte, owner
//   done/done_id        - one-cycle end-of-transaction pulse and owner
//   abort               - terminate the current transaction
//   spi_cs/sclk/mosi/miso - SPI bus (cs active high, mode 0)
import spi_sched_pkg::*;

module spi_rom_sched #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic [1:0]        gnt,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              rd_id,
  output logic              done,
  output logic              done_id,
  input  logic              abort,
  output logic              spi_cs,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned ADDR_BYTES = ADDR_W / 8;
  localparam int unsigned AC_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  state_t            state;
  logic              id;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  data_cnt;
  logic [AC_W-1:0]   addr_cnt;
  logic [1:0]        gap_cnt;

  logic              grant;
  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic              active;
  logic              last_byte;
  logic              finish;
  logic              stop;
  logic              byte_end;
  logic              sample_last;
  logic [7:0]        rx_next;

`ifdef SPI_SCHED_RR_EN
  // Requester preferred on contention: the one not granted last.
  logic              rr_ptr;
`endif

  always_comb begin
    grant = (state == IDLE) && (|req);
`ifdef SPI_SCHED_RR_EN
    win = (req == 2'b11) ? rr_ptr : ~req[0];
`else
    win = ~req[0];
`endif
    sel_addr  = win ? addr1 : addr0;
    active    = (state == CMD) || (state == ADDR) || (state == DATA);
    // len_q of 0 wraps len_q-1 to all ones, giving 2^LEN_W bytes.
    last_byte = (data_cnt == (len_q - LEN_W'(1)));
    finish    = (state == DATA) && byte_end && last_byte;
    stop      = active && (abort || finish);
  end

  spi_shift #(
    .ADDR_W(ADDR_W)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (grant),
    .stop       (stop),
    .active     (active),
    .addr       (sel_addr),
    .miso       (spi_miso),
    .sclk       (spi_sclk),
    .mosi       (spi_mosi),
    .byte_end   (byte_end),
    .sample_last(sample_last),
    .rx_next    (rx_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      id       <= 1'b0;
      len_q    <= '0;
      data_cnt <= '0;
      addr_cnt <= '0;
      gap_cnt  <= '0;
      spi_cs   <= 1'b0;
      gnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_id    <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
`ifdef SPI_SCHED_RR_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      gnt      <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            id       <= win;
            len_q    <= win ? len1 : len0;
            gnt      <= win ? 2'b10 : 2'b01;
            spi_cs   <= 1'b1;
            addr_cnt <= '0;
            data_cnt <= '0;
            state    <= CMD;
`ifdef SPI_SCHED_RR_EN
            rr_ptr   <= ~win;
`endif
          end
        end
        CMD, ADDR, DATA: begin
          if (abort || finish) begin
            spi_cs  <= 1'b0;
            done    <= 1'b1;
            done_id <= id;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            case (state)
              CMD: begin
                if (byte_end) state <= ADDR;
              end
              ADDR: begin
                if (byte_end) begin
                  if (addr_cnt == AC_W'(ADDR_BYTES - 1)) state <= DATA;
                  else addr_cnt <= addr_cnt + AC_W'(1);
                end
              end
              default: begin
                if (sample_last) begin
                  rd_valid <= 1'b1;
                  rd_data  <= rx_next;
                  rd_id    <= id;
                end
                if (byte_end) data_cnt <= data_cnt + LEN_W'(1);
              end
            endcase
          end
        end
        GAP: begin
          if (gap_cnt == 2'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_sched.sv
// tb_spi_rom_sched: directed, table-driven bench for spi_rom_sched
// (ADDR_W=24, LEN_W=8). Expected grant order follows SPI_SCHED_RR_EN.
module tb_spi_rom_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [23:0] addr0, addr1;
  logic [7:0]  len0, len1;
  logic [1:0]  gnt;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_id;
  logic        done;
  logic        done_id;
  logic        abort;
  logic        spi_cs, spi_sclk, spi_mosi, spi_miso;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  spi_rom_sched #(
    .ADDR_W(24),
    .LEN_W (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .addr0   (addr0),
    .addr1   (addr1),
    .len0    (len0),
    .len1    (len1),
    .gnt     (gnt),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_id   (rd_id),
    .done    (done),
    .done_id (done_id),
    .abort   (abort),
    .spi_cs  (spi_cs),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte k returned by the memory model for a given seed.
  function automatic logic [7:0] pat(input logic [7:0] seed, input int k);
    return seed + 8'(k * 151);
  endfunction

  // Waits (bounded) for a grant, then follows the transaction cycle by cycle
  // from cycle 0, acting as the flash on MISO and optionally raising abort.
  task automatic run_txn(input string tag, input logic exp_id, input logic [23:0] exp_addr,
                         input int nbytes, input int abort_cyc, input logic [7:0] seed,
                         input logic [1:0] req_after);
    int end_c;
    int k;
    int t_err;
    int v_seen;
    logic [31:0] cap;
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      if (gnt != 2'b00) break;
      @(negedge clk);
    end
    chk($sformatf("%s/gnt", tag), gnt, exp_id ? 2'b10 : 2'b01);
    if (gnt == 2'b00) return;
    req = req_after;
    end_c  = (abort_cyc >= 0) ? abort_cyc + 1 : 64 + 16 * nbytes;
    cap    = '0;
    t_err  = 0;
    v_seen = 0;
    for (int c = 0; c <= end_c + 2; c++) begin
      if (c < end_c) begin
        if (spi_cs !== 1'b1 || spi_sclk !== c[0] || done !== 1'b0) t_err++;
        if (c > 0 && gnt !== 2'b00) t_err++;
        if (c < 64 && !c[0]) cap = {cap[30:0], spi_mosi};
        if (c >= 79 && (c - 79) % 16 == 0) begin
          if (rd_valid !== 1'b1) t_err++;
          else begin
            k = (c - 79) / 16;
            chk($sformatf("%s/byte%0d", tag, k), {rd_id, rd_data}, {exp_id, pat(seed, k)});
            v_seen++;
          end
        end else if (rd_valid !== 1'b0) t_err++;
      end else if (c == end_c) begin
        chk($sformatf("%s/done", tag), {spi_cs, spi_sclk, rd_valid, done, done_id},
            {1'b0, 1'b0, 1'b0, 1'b1, exp_id});
      end else begin
        if (spi_cs !== 1'b0 || done !== 1'b0 || gnt !== 2'b00) t_err++;
      end
      spi_miso = 1'b0;
      if (c >= 64 && c < end_c) begin
        b = pat(seed, (c - 64) / 16);
        spi_miso = b[7 - ((c - 64) % 16) / 2];
      end
      abort = (c == abort_cyc);
      @(negedge clk);
    end
    if (end_c >= 64) chk($sformatf("%s/mosi", tag), cap, {8'h03, exp_addr});
    chk($sformatf("%s/timing", tag), t_err, 0);
    chk($sformatf("%s/nbytes", tag), v_seen, nbytes);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [23:0] a0;
    logic [7:0]  l0;
    logic [23:0] a1;
    logic [7:0]  l1;
    logic        exp_id;
    int          nbytes;
    int          abort_cyc;
    logic [7:0]  seed;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic [3:0] seq_bits;
    logic [23:0] ea;
    int t;

    tbl[0] = '{2'b01, 24'h012345, 8'd2, 24'h000000, 8'd0, 1'b0, 2, -1, 8'hA5};
    tbl[1] = '{2'b10, 24'h000000, 8'd0, 24'hABCDEF, 8'd1, 1'b1, 1, -1, 8'h5A};
    tbl[2] = '{2'b11, 24'h000010, 8'd3, 24'hFFFFFF, 8'd2, 1'b0, 3, -1, 8'hC3};
    tbl[3] = '{2'b10, 24'h000010, 8'd3, 24'hFFFFFF, 8'd2, 1'b1, 2, -1, 8'h0F};
    tbl[4] = '{2'b01, 24'h00ABCD, 8'd4, 24'h000000, 8'd0, 1'b0, 0, 70, 8'h11};
    tbl[5] = '{2'b10, 24'h000000, 8'd0, 24'h123456, 8'd2, 1'b1, 0, 78, 8'h22};
    tbl[6] = '{2'b01, 24'h765432, 8'd2, 24'h000000, 8'd0, 1'b0, 0, 5,  8'h33};
    tbl[7] = '{2'b01, 24'hFEDCBA, 8'd3, 24'h000000, 8'd0, 1'b0, 1, 94, 8'h44};

    rst_n = 1'b0; req = '0; addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    abort = 1'b0; spi_miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {spi_cs, spi_sclk, spi_mosi, gnt, rd_valid, rd_data, rd_id, done, done_id}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      addr0 = tbl[i].a0; len0 = tbl[i].l0;
      addr1 = tbl[i].a1; len1 = tbl[i].l1;
      ea = tbl[i].exp_id ? tbl[i].a1 : tbl[i].a0;
      run_txn($sformatf("vec%0d", i), tbl[i].exp_id, ea, tbl[i].nbytes, tbl[i].abort_cyc,
              tbl[i].seed, tbl[i].req & ~(tbl[i].exp_id ? 2'b10 : 2'b01));
    end

    // len of 0 means 256 bytes
    req = 2'b10; addr1 = 24'h000100; len1 = 8'd0;
    run_txn("len256", 1'b1, 24'h000100, 256, -1, 8'h77, 2'b00);

    // Both requesters held for four transactions, starting from reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef SPI_SCHED_RR_EN
    seq_bits = 4'b1010;
`else
    seq_bits = 4'b0000;
`endif
    addr0 = 24'h111111; len0 = 8'd1; addr1 = 24'h222222; len1 = 8'd1;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_txn($sformatf("contend%0d", i), seq_bits[i], seq_bits[i] ? 24'h222222 : 24'h111111,
              1, -1, 8'h60 + 8'(i), (i == 3) ? 2'b00 : 2'b11);
    end

    // Reset in cycle 40 of a transaction
    req = 2'b01; addr0 = 24'h0A0B0C; len0 = 8'd2;
    for (int i = 0; i < 40; i++) begin
      if (gnt != 2'b00) break;
      @(negedge clk);
    end
    chk("rst_mid/gnt", gnt, 2'b01);
    req = 2'b00;
    t = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || spi_cs !== 1'b1) t++;
      @(negedge clk);
    end
    chk("rst_mid/pre", t, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid/outputs", {spi_cs, spi_sclk, spi_mosi, gnt, rd_valid, rd_data, rd_id, done, done_id}, '0);
    rst_n = 1'b1;
    t = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || spi_cs !== 1'b0 || gnt !== 2'b00) t++;
    end
    chk("rst_mid/quiet", t, 0);
    req = 2'b01;
    run_txn("rst_mid/clean", 1'b0, 24'h0A0B0C, 2, -1, 8'h99, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_rom_sched.md
SPI_ROM_SCHED -- requirements
Module: spi_rom_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, the SPI memory address width in bits (must be a multiple of 8).
REQ-002 SHALL have parameter LEN_W, default 8, the burst length field width.
REQ-003 SHALL have port clk  input  1  the single system clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req[1:0]  input  2  read requests; req[0] is the video line fetch, req[1] is the auxiliary requester.
REQ-006 SHALL have ports addr0/addr1  input  ADDR_W  start address per requester.
REQ-007 SHALL have ports len0/len1  input  LEN_W  byte count per requester, where 0 means 2^LEN_W.
REQ-008 SHALL have port gnt  output  2  a one-cycle grant pulse to the selected requester.
REQ-009 SHALL have ports rd_valid  output  1, rd_data  output  8 and rd_id  output  1, giving the received byte and its owner.
REQ-010 SHALL have port done  output  1  a one-cycle pulse at transaction end, with done_id  output  1.
REQ-011 SHALL have port abort  input  1  which terminates the current transaction.
REQ-012 SHALL have ports spi_cs (output, 1, active-HIGH), spi_sclk (output, 1), spi_mosi (output, 1) and spi_miso (input, 1).

Function
REQ-013 SHALL implement states IDLE, CMD, ADDR, DATA and GAP.
REQ-014 IDLE SHALL grant on the edge where any req is high, and capture that requester's addr and len on the same edge.
REQ-015 In the next cycle (cycle 0), spi_cs=1 and gnt[id]=1 for exactly one cycle.
REQ-016 Requesters SHALL hold req, addr and len stable until they see gnt; req changes after gnt SHALL be ignored until the next IDLE.
REQ-017 spi_sclk SHALL be clk/2, low in even cycles and high in odd cycles counted from cycle 0 (SPI mode 0).
REQ-018 spi_mosi SHALL change only in low phases, MSB first: command 8'h03 in cycles 0-15, then the address in cycles 16-(16+2*ADDR_W-1).
REQ-019 spi_miso SHALL be sampled on the clk edge at which spi_sclk goes 0->1, and assembled MSB first.
REQ-020 With ADDR_W=24, byte k SHALL appear as rd_valid=1 for one cycle in cycle 79+16k; rd_data and rd_id are valid only in that cycle.
REQ-021 The cycle after the last rd_valid SHALL have spi_cs=0, spi_sclk=0, done=1 and done_id set, and SHALL enter GAP.
REQ-022 GAP SHALL last 2 cycles with spi_cs=0, then go to IDLE; the next spi_cs rise therefore comes at least 3 cycles after done.
REQ-023 abort=1 in CMD, ADDR or DATA SHALL make the next cycle spi_cs=0 with done=1, suppress the partial byte (no rd_valid), and enter GAP; abort in IDLE or GAP SHALL be ignored.
REQ-024 Simultaneous req[0] and req[1] in IDLE SHALL be resolved per REQ-027 and REQ-028; the loser stays pending.
REQ-025 A len of 0 SHALL transfer 2^LEN_W bytes, and the address SHALL NOT be incremented locally (the memory auto-increments).

Reset
REQ-026 While rst_n=0 at a clk edge, the block SHALL go to IDLE with spi_cs=0, spi_sclk=0, spi_mosi=0, gnt=0, rd_valid=0, rd_data=0, rd_id=0, done=0, done_id=0 and the round-robin pointer=0; a reset mid-transaction SHALL produce no done pulse.

Configuration
REQ-027 Without SPI_SCHED_RR_EN, arbitration SHALL be fixed priority: req[0] always wins.
REQ-028 With SPI_SCHED_RR_EN defined, arbitration SHALL be round-robin: on contention, the requester not granted last wins, the pointer updates at each gnt, and the first contention after reset goes to req[0].

Structure
REQ-029 Shared package spi_sched_pkg SHALL hold the state enum, READ_CMD=8'h03 and GAP_CYCLES=2.
REQ-030 The bit serializer/deserializer (sclk phase, MOSI shift, MISO shift and bit counter) SHALL be the sub-module spi_shift; the arbiter and FSM stay in spi_rom_sched.

Verification
REQ-031 Scenario: req[0]=1, addr0=24'h012345, len0=2, MISO model returns A5 and 3C -> MOSI sends 03 01 23 45; rd_valid in cycles 79 and 95 with A5 and 3C, rd_id=0; done in cycle 96.
REQ-032 Scenario: both requests high in IDLE, fixed priority -> gnt[0] first, gnt[1] at least 3 cycles after done.
REQ-033 Scenario: SPI_SCHED_RR_EN defined, both requests held high for 4 transactions -> grants alternate 0,1,0,1.
REQ-034 Scenario: abort in cycle 70 -> spi_cs=0 and done=1 in cycle 71, no rd_valid, then 2 GAP cycles.
REQ-035 Scenario: len1=0 -> 256 rd_valid pulses spaced 16 cycles apart, then one done with done_id=1.
REQ-036 Scenario: rst_n=0 in cycle 40 of a transaction -> all outputs at reset values on the next edge, no done, and a clean new transaction after release.
